// File: rtl/clock_set_controller.sv
// Time-setting sequencer: HH -> MM -> SS edit fields, timekeeper hold/load, field blink masks.
// Define AUTO_REPEAT_EN to enable UP/DOWN auto-repeat while a key is held.
module clock_set_controller #(
    parameter int BLINK_MS        = 250,
    parameter int TIMEOUT_MS      = 10000,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick_1khz,
    input  logic       i_key_mode,
    input  logic       i_key_up,
    input  logic       i_key_down,
    input  logic [4:0] i_cur_hh,
    input  logic [5:0] i_cur_mm,
    input  logic [5:0] i_cur_ss,
    output logic [4:0] o_hh,
    output logic [5:0] o_mm,
    output logic [5:0] o_ss,
    output logic       o_load,
    output logic       o_hold,
    output logic [1:0] o_field,
    output logic [2:0] o_blank
);

    localparam int TO_W    = $clog2(TIMEOUT_MS + 1);
    localparam int BL_W    = $clog2(BLINK_MS + 1);
    localparam int REP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_MS - 1);
    localparam logic [TO_W-1:0]  TO_TERM = TO_W'(TIMEOUT_MS);
    localparam logic [BL_W-1:0]  BL_LAST = BL_W'(BLINK_MS - 1);
    localparam logic [REP_W-1:0] RD_LAST = REP_W'(REPEAT_DELAY_MS - 1);
    localparam logic [REP_W-1:0] RR_LAST = REP_W'(REPEAT_RATE_MS - 1);

`ifdef AUTO_REPEAT_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_HH = 3'd1,
        ST_SET_MM = 3'd2,
        ST_SET_SS = 3'd3,
        ST_LOAD   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic       mode_q_reg, up_q_reg, down_q_reg, armed_reg;
    logic       mode_press, up_press, down_press, any_press;
    logic       in_edit, entry, timeout_hit;
    logic       step_up, step_dn, step;
    logic [4:0] hh_reg, hh_next;
    logic [5:0] mm_reg, mm_next;
    logic [5:0] ss_reg, ss_next;
    logic       load_reg, hold_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic [BL_W-1:0]  blink_cnt_reg;
    logic             phase_reg;
    logic [REP_W-1:0] rep_cnt_reg, rep_limit;
    logic             rep_arm_reg, rep_first_reg;
    logic             up_alone, dn_alone, rep_hold, rep_fire;

    // armed_reg masks the first cycle after reset so a key held through reset is not a press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q_reg <= 1'b1;
            up_q_reg   <= 1'b1;
            down_q_reg <= 1'b1;
            armed_reg  <= 1'b0;
        end else begin
            mode_q_reg <= i_key_mode;
            up_q_reg   <= i_key_up;
            down_q_reg <= i_key_down;
            armed_reg  <= 1'b1;
        end
    end

    assign mode_press = armed_reg & mode_q_reg & ~i_key_mode;
    assign up_press   = armed_reg & up_q_reg & ~i_key_up;
    assign down_press = armed_reg & down_q_reg & ~i_key_down;
    assign any_press  = mode_press | up_press | down_press;

    assign in_edit = (state_reg == ST_SET_HH) | (state_reg == ST_SET_MM) | (state_reg == ST_SET_SS);

    // Auto-repeat only runs after a genuine press of a single key inside an edit field.
    assign up_alone  = ~i_key_up & i_key_down;
    assign dn_alone  = i_key_up & ~i_key_down;
    assign rep_hold  = REPEAT_EN & in_edit & ~mode_press & (up_alone | dn_alone);
    assign rep_limit = rep_first_reg ? RD_LAST : RR_LAST;
    assign rep_fire  = rep_hold & rep_arm_reg & ~up_press & ~down_press & i_tick_1khz
                     & (rep_cnt_reg == rep_limit);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rep_arm_reg   <= 1'b0;
            rep_cnt_reg   <= '0;
            rep_first_reg <= 1'b1;
        end else if (!rep_hold) begin
            rep_arm_reg   <= 1'b0;
            rep_cnt_reg   <= '0;
            rep_first_reg <= 1'b1;
        end else if (up_press || down_press) begin
            rep_arm_reg   <= 1'b1;
            rep_cnt_reg   <= '0;
            rep_first_reg <= 1'b1;
        end else if (rep_arm_reg && i_tick_1khz) begin
            if (rep_cnt_reg == rep_limit) begin
                rep_cnt_reg   <= '0;
                rep_first_reg <= 1'b0;
            end else begin
                rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
            end
        end
    end

    assign step_up = in_edit & ~mode_press & ((up_press & ~down_press) | (rep_fire & up_alone));
    assign step_dn = in_edit & ~mode_press & ((down_press & ~up_press) | (rep_fire & dn_alone));
    assign step    = step_up | step_dn;

    assign timeout_hit = i_tick_1khz & (to_cnt_reg == TO_LAST);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_RUN:    if (mode_press) state_next = ST_SET_HH;
            ST_SET_HH: if (mode_press) state_next = ST_SET_MM;
                       else if (timeout_hit) state_next = ST_RUN;
            ST_SET_MM: if (mode_press) state_next = ST_SET_SS;
                       else if (timeout_hit) state_next = ST_RUN;
            ST_SET_SS: if (mode_press) state_next = ST_LOAD;
                       else if (timeout_hit) state_next = ST_RUN;
            ST_LOAD:   state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    assign entry = (state_next != state_reg);

    always_comb begin
        hh_next = hh_reg;
        mm_next = mm_reg;
        ss_next = ss_reg;
        if (state_reg == ST_RUN && mode_press) begin
            hh_next = i_cur_hh;
            mm_next = i_cur_mm;
            ss_next = i_cur_ss;
        end else if (step) begin
            unique case (state_reg)
                ST_SET_HH: hh_next = step_up ? ((hh_reg == 5'd23) ? 5'd0 : hh_reg + 5'd1)
                                             : ((hh_reg == 5'd0) ? 5'd23 : hh_reg - 5'd1);
                ST_SET_MM: mm_next = step_up ? ((mm_reg == 6'd59) ? 6'd0 : mm_reg + 6'd1)
                                             : ((mm_reg == 6'd0) ? 6'd59 : mm_reg - 6'd1);
                ST_SET_SS: ss_next = step_up ? ((ss_reg == 6'd59) ? 6'd0 : ss_reg + 6'd1)
                                             : ((ss_reg == 6'd0) ? 6'd59 : ss_reg - 6'd1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_RUN;
            hh_reg    <= '0;
            mm_reg    <= '0;
            ss_reg    <= '0;
            load_reg  <= 1'b0;
            hold_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hh_reg    <= hh_next;
            mm_reg    <= mm_next;
            ss_reg    <= ss_next;
            load_reg  <= (state_next == ST_LOAD);
            hold_reg  <= (state_next != ST_RUN);
        end
    end

    // Idle timeout saturates at its terminal count; blink restarts visible on entry and on each step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt_reg    <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else begin
            if (entry || any_press || step)
                to_cnt_reg <= '0;
            else if (i_tick_1khz && to_cnt_reg != TO_TERM)
                to_cnt_reg <= to_cnt_reg + TO_W'(1);

            if (entry || step) begin
                blink_cnt_reg <= '0;
                phase_reg     <= 1'b0;
            end else if (i_tick_1khz) begin
                if (blink_cnt_reg == BL_LAST) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + BL_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_field = 2'd0;
        o_blank = 3'b000;
        unique case (state_reg)
            ST_SET_HH: begin o_field = 2'd1; o_blank = {phase_reg, 2'b00}; end
            ST_SET_MM: begin o_field = 2'd2; o_blank = {1'b0, phase_reg, 1'b0}; end
            ST_SET_SS: begin o_field = 2'd3; o_blank = {2'b00, phase_reg}; end
            default: ;
        endcase
    end

    assign o_hh   = hh_reg;
    assign o_mm   = mm_reg;
    assign o_ss   = ss_reg;
    assign o_load = load_reg;
    assign o_hold = hold_reg;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller: directed scenarios then random key/tick traffic
// against a transaction-level model of the time-setting rules.
module tb_clock_set_controller;

    localparam int BL = 3;
    localparam int TO = 40;
    localparam int RD = 6;
    localparam int RR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       key_mode, key_up, key_down;
    logic [4:0] cur_hh;
    logic [5:0] cur_mm, cur_ss;
    logic [4:0] o_hh;
    logic [5:0] o_mm, o_ss;
    logic       o_load, o_hold;
    logic [1:0] o_field;
    logic [2:0] o_blank;

    always #5 clk = ~clk;

    clock_set_controller #(
        .BLINK_MS(BL), .TIMEOUT_MS(TO), .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_tick_1khz(tick),
        .i_key_mode(key_mode), .i_key_up(key_up), .i_key_down(key_down),
        .i_cur_hh(cur_hh), .i_cur_mm(cur_mm), .i_cur_ss(cur_ss),
        .o_hh(o_hh), .o_mm(o_mm), .o_ss(o_ss), .o_load(o_load), .o_hold(o_hold),
        .o_field(o_field), .o_blank(o_blank)
    );

    int checks = 0;
    int failures = 0;
    int loads_seen = 0;

    // Model: m_st 0 = running, 1..3 = editing HH/MM/SS; m_load_now marks the load cycle.
    int m_st, m_h, m_m, m_s, m_idle, m_bt, m_loads, m_held;
    bit m_load_now;

    always @(negedge clk) if (o_load === 1'b1) loads_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_blank;
        exp_blank = 0;
        if (m_st != 0 && ((m_bt / BL) % 2) == 1) exp_blank = 4 >> (m_st - 1);
        $display("%0t %s hh=%0d mm=%0d ss=%0d field=%0d hold=%0b load=%0b blank=%b",
                 $time, tag, o_hh, o_mm, o_ss, o_field, o_hold, o_load, o_blank);
        chk({tag, ".hh"},    32'(o_hh),    m_h);
        chk({tag, ".mm"},    32'(o_mm),    m_m);
        chk({tag, ".ss"},    32'(o_ss),    m_s);
        chk({tag, ".field"}, 32'(o_field), m_st);
        chk({tag, ".hold"},  32'(o_hold),  (m_st != 0 || m_load_now) ? 1 : 0);
        chk({tag, ".load"},  32'(o_load),  m_load_now ? 1 : 0);
        chk({tag, ".blank"}, 32'(o_blank), exp_blank);
        chk({tag, ".nload"}, loads_seen,   m_loads);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_step(input bit up);
        case (m_st)
            1: m_h = up ? (m_h + 1) % 24 : (m_h + 23) % 24;
            2: m_m = up ? (m_m + 1) % 60 : (m_m + 59) % 60;
            3: m_s = up ? (m_s + 1) % 60 : (m_s + 59) % 60;
            default: ;
        endcase
        m_bt = 0;
        m_idle = 0;
    endfunction

    function automatic void model_press(input bit pm, input bit pu, input bit pd);
        m_idle = 0;
        m_held = 0;
        if (pm) begin
            if (m_st == 0) begin
                m_h = int'(cur_hh); m_m = int'(cur_mm); m_s = int'(cur_ss);
                m_st = 1;
            end else if (m_st < 3) begin
                m_st++;
            end else begin
                m_st = 0;
                m_load_now = 1'b1;
            end
            m_bt = 0;
        end else if (m_st != 0 && pu != pd) begin
            model_step(pu);
        end
    endfunction

    function automatic void model_tick(input bit holding_up);
        m_idle++;
        m_bt++;
        if (m_st != 0 && m_idle >= TO) begin
            m_st = 0;
            m_bt = 0;
        end
        if (holding_up) m_held++;
`ifdef AUTO_REPEAT_EN
        if (holding_up && m_st != 0 && (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)))
            model_step(1'b1);
`endif
    endfunction

    function automatic void model_reset();
        m_st = 0; m_h = 0; m_m = 0; m_s = 0;
        m_idle = 0; m_bt = 0; m_held = 0; m_load_now = 1'b0;
    endfunction

    task automatic do_ticks(input int n, input bit holding_up);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            model_tick(holding_up);
            cyc();
        end
    endtask

    task automatic press(input string tag, input bit pm, input bit pu, input bit pd);
        key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
        cyc();
        key_mode = ~pm; key_up = ~pu; key_down = ~pd;
        cyc();
        key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
        model_press(pm, pu, pd);
        check_all(tag);
        if (m_load_now) begin
            cyc();
            m_load_now = 1'b0;
            m_loads++;
            check_all({tag, ".after"});
        end
    endtask

    task automatic hold_up(input string tag, input int n);
        key_up = 1'b1;
        cyc();
        key_up = 1'b0;
        cyc();
        model_press(1'b0, 1'b1, 1'b0);
        check_all({tag, ".press"});
        do_ticks(n, 1'b1);
        key_up = 1'b1;
        cyc();
        check_all({tag, ".release"});
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hh = 5'(h); cur_mm = 6'(m); cur_ss = 6'(s);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0;
        key_mode = 1'b1; key_up = 1'b1; key_down = 1'b1;
        set_cur(0, 0, 0);
        model_reset();
        m_loads = 0;
        cyc(); cyc();
        check_all("reset");
        rst = 1'b0;
        cyc();
        check_all("post_reset");

        // 12:34:56 -> +2 h, -1 min -> load 14:33:56
        set_cur(12, 34, 56);
        press("t1.mode", 1, 0, 0);
        chk("t1.hold_rises", 32'(o_hold), 1);
        press("t1.up1", 0, 1, 0);
        press("t1.up2", 0, 1, 0);
        press("t1.mode2", 1, 0, 0);
        press("t1.down", 0, 0, 1);
        press("t1.mode3", 1, 0, 0);
        chk("t1.hh14", 32'(o_hh), 14);
        chk("t1.mm33", 32'(o_mm), 33);
        chk("t1.ss56", 32'(o_ss), 56);
        press("t1.load", 1, 0, 0);
        chk("t1.one_load", loads_seen, 1);

        // wrap boundaries
        set_cur(23, 0, 59);
        press("t2.mode", 1, 0, 0);
        press("t2.hh_up", 0, 1, 0);
        chk("t2.hh_wrap", 32'(o_hh), 0);
        press("t2.mode2", 1, 0, 0);
        press("t2.mm_dn", 0, 0, 1);
        chk("t2.mm_wrap", 32'(o_mm), 59);
        press("t2.mode3", 1, 0, 0);
        press("t2.ss_up", 0, 1, 0);
        chk("t2.ss_wrap", 32'(o_ss), 0);
        press("t2.load", 1, 0, 0);

        // idle timeout in SET_MM with blink observed on the way
        set_cur(5, 6, 7);
        press("t3.mode", 1, 0, 0);
        press("t3.mode2", 1, 0, 0);
        do_ticks(BL, 1'b0);
        check_all("t3.blink");
        chk("t3.blank_mm", 32'(o_blank), 2);
        do_ticks(TO - 1 - BL, 1'b0);
        check_all("t3.before_to");
        do_ticks(1, 1'b0);
        check_all("t3.timeout");
        chk("t3.hold_low", 32'(o_hold), 0);

        // MODE beats UP; UP+DOWN together makes no step
        set_cur(9, 30, 45);
        press("t4.mode", 1, 0, 0);
        press("t4.mode_up", 1, 1, 0);
        chk("t4.hh_same", 32'(o_hh), 9);
        chk("t4.field_mm", 32'(o_field), 2);
        press("t4.up_down", 0, 1, 1);
        chk("t4.mm_same", 32'(o_mm), 30);
        press("t4.mode2", 1, 0, 0);
        press("t4.load", 1, 0, 0);

        // held UP in SET_SS from 10
        set_cur(1, 2, 10);
        press("t5.mode", 1, 0, 0);
        press("t5.mode2", 1, 0, 0);
        press("t5.mode3", 1, 0, 0);
        hold_up("t5.hold", RD + 3 * RR);
`ifdef AUTO_REPEAT_EN
        chk("t5.ss_repeat", 32'(o_ss), 15);
`else
        chk("t5.ss_single", 32'(o_ss), 11);
`endif
        press("t5.load", 1, 0, 0);

        // async reset mid-edit with MODE held through reset
        set_cur(3, 4, 5);
        press("t6.mode", 1, 0, 0);
        press("t6.mode2", 1, 0, 0);
        press("t6.mode3", 1, 0, 0);
        key_mode = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.in_reset");
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        check_all("t6.held_mode");
        key_mode = 1'b1;
        cyc();
        check_all("t6.released");

        // random traffic
        for (int n = 0; n < 120; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (m_st == 0)
                set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            case (r)
                0, 1: press($sformatf("rnd%0d.mode", n), 1, 0, 0);
                2, 3: press($sformatf("rnd%0d.up", n), 0, 1, 0);
                4, 5: press($sformatf("rnd%0d.down", n), 0, 0, 1);
                6:    press($sformatf("rnd%0d.mode_up", n), 1, 1, 0);
                7:    press($sformatf("rnd%0d.up_down", n), 0, 1, 1);
                default: begin
                    do_ticks($urandom_range(1, 25), 1'b0);
                    check_all($sformatf("rnd%0d.ticks", n));
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
